// File: rtl/joy_event_pkg.sv
// ----------------------------------------------------------------------------
// joy_event_pkg
// Shared constants, types and helpers for the joystick event queue.
//   EVT_W            width of one queued event word
//   EVT_*_LSB/_W     field layout of an event word:
//                    [15] pressed, [14:12] player, [11:4] frame[7:0], [3:0] bit
//   MAX_SCAN_PLAYERS players that can ever be scanned (0..3)
//   PLAYER_WORD_W    width of one player word on the joystick bus
//   scan_state_e     scan sequencer states (IDLE, SCAN)
//   make_event()     packs the event fields into one event word
// ----------------------------------------------------------------------------
package joy_event_pkg;

    localparam int EVT_W            = 16;
    localparam int EVT_PRESSED_BIT  = 15;
    localparam int EVT_PLAYER_LSB   = 12;
    localparam int EVT_PLAYER_W     = 3;
    localparam int EVT_FRAME_LSB    = 4;
    localparam int EVT_FRAME_W      = 8;
    localparam int EVT_BIT_LSB      = 0;
    localparam int EVT_BIT_W        = 4;

    localparam int MAX_SCAN_PLAYERS = 4;
    localparam int PLAYER_WORD_W    = 32;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_e;

    function automatic logic [EVT_W-1:0] make_event(
        input logic                    pressed,
        input logic [EVT_PLAYER_W-1:0] player,
        input logic [EVT_FRAME_W-1:0]  frame,
        input logic [EVT_BIT_W-1:0]    bit_idx
    );
        logic [EVT_W-1:0] evt;
        evt                                   = '0;
        evt[EVT_PRESSED_BIT]                  = pressed;
        evt[EVT_PLAYER_LSB +: EVT_PLAYER_W]   = player;
        evt[EVT_FRAME_LSB  +: EVT_FRAME_W]    = frame;
        evt[EVT_BIT_LSB    +: EVT_BIT_W]      = bit_idx;
        return evt;
    endfunction

endpackage

// File: rtl/event_fifo.sv
// ----------------------------------------------------------------------------
// event_fifo
// Synchronous first-word-fall-through FIFO holding joystick events.
// The head entry is visible on head_data whenever empty is low; pop removes
// it in the same cycle. A push while full is accepted only when a pop frees
// a slot in that same cycle. When empty, head_data holds the last popped
// word (zero after reset).
// Ports:
//   clk_sys    clock, rising edge
//   reset      asynchronous active-high reset
//   push       write push_data (ignored when full and not popping)
//   push_data  word to write
//   pop        remove head entry (ignored when empty)
//   head_data  current head entry / last popped word when empty
//   empty      no entries stored
//   full       DEPTH entries stored
// ----------------------------------------------------------------------------
module event_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full
);

    localparam int           AW        = $clog2(DEPTH);
    localparam logic [AW:0]  DEPTH_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic [WIDTH-1:0] hold_q,   hold_d;

    logic pop_ok;
    logic push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == DEPTH_CNT);
    assign pop_ok  = pop && !empty;
    // A pop in the same cycle frees the slot, so push-while-full is legal then.
    assign push_ok = push && (!full || pop_ok);

    assign head_data = empty ? hold_q : mem[rd_ptr_q];

    // NOTE: every signal gets a default at the top of an always_comb so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        hold_d   = hold_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            hold_d   = mem[rd_ptr_q];
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state is written with non-blocking assignments so all
    // flops update together from values sampled before the clock edge.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            hold_q   <= hold_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; entries are only
    // visible once written, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk_sys) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/joy_event_queue.sv
// ----------------------------------------------------------------------------
// joy_event_queue
// On each rising edge of vblank (while idle) the joystick state of players
// 0-3 is snapshotted and the frame counter advances. A scan then visits one
// (player, bit) per cycle, player-major, bit 0 first, over 2 or 4 players
// (chosen by player_count at snapshot time). Every bit that differs from its
// stored previous value produces a press/release event in an FWFT FIFO.
// Optional build macro JOY_EVENT_DEBOUNCE_EN: a bit must differ on two
// consecutive scans before its event is produced.
// Ports:
//   clk_sys       clock, rising edge
//   reset         asynchronous active-high reset
//   joystick      six 32-bit player words, player 0 in [31:0]
//   player_count  0 = scan players 0-1, 1 = scan players 0-3
//   vblank        vertical blank; rising edge starts a scan
//   rd            pop head event
//   clr_overflow  clear sticky overflow
//   event_data    head event {pressed, player[2:0], frame[7:0], bit[3:0]}
//   event_valid   FIFO non-empty
//   overflow      sticky: an event was dropped on a full FIFO
//   busy          scan in progress
// ----------------------------------------------------------------------------
module joy_event_queue
    import joy_event_pkg::*;
#(
    parameter int FIFO_DEPTH      = 16,
    parameter int BITS_PER_PLAYER = 16
) (
    input  logic             clk_sys,
    input  logic             reset,
    input  logic [191:0]     joystick,
    input  logic             player_count,
    input  logic             vblank,
    input  logic             rd,
    input  logic             clr_overflow,
    output logic [EVT_W-1:0] event_data,
    output logic             event_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int SCAN_BITS = MAX_SCAN_PLAYERS * BITS_PER_PLAYER;
    localparam int IDX_W     = $clog2(SCAN_BITS);
    localparam int BIT_W     = (BITS_PER_PLAYER > 1) ? $clog2(BITS_PER_PLAYER) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(BITS_PER_PLAYER - 1);

    scan_state_e          state_q,    state_d;
    logic                 vblank_q;
    logic [7:0]           frame_q,    frame_d;
    logic [SCAN_BITS-1:0] snap_q,     snap_d;
    logic [SCAN_BITS-1:0] prev_q,     prev_d;
    logic                 four_q,     four_d;
    logic [1:0]           player_q,   player_d;
    logic [BIT_W-1:0]     bit_q,      bit_d;
    logic                 busy_q,     busy_d;
    logic                 overflow_q, overflow_d;
`ifdef JOY_EVENT_DEBOUNCE_EN
    logic [SCAN_BITS-1:0] pend_q,     pend_d;
`endif

    logic             vblank_rise;
    logic [IDX_W-1:0] scan_idx;
    logic             cur_bit;
    logic             prev_bit;
    logic [1:0]       last_player;
    logic             push_req;
    logic [EVT_W-1:0] push_evt;
    logic             fifo_full;
    logic             fifo_empty;
    logic             drop;

    // Players 4-5 and bits at or above BITS_PER_PLAYER are intentionally
    // ignored; folding the bus here keeps those bits from looking forgotten.
    logic unused_joystick;
    assign unused_joystick = ^joystick;

    assign vblank_rise = vblank && !vblank_q;
    assign scan_idx    = IDX_W'(32'(player_q) * BITS_PER_PLAYER) + IDX_W'(bit_q);
    assign cur_bit     = snap_q[scan_idx];
    assign prev_bit    = prev_q[scan_idx];
    assign last_player = four_q ? 2'd3 : 2'd1;
    // frame_q already holds this scan's number once SCAN is entered.
    assign push_evt    = make_event(cur_bit, {1'b0, player_q}, frame_q, EVT_BIT_W'(bit_q));
    // A drop happens only when full with no pop to make room.
    assign drop        = push_req && fifo_full && !rd;

    always_comb begin
        state_d    = state_q;
        frame_d    = frame_q;
        snap_d     = snap_q;
        prev_d     = prev_q;
        four_d     = four_q;
        player_d   = player_q;
        bit_d      = bit_q;
        busy_d     = busy_q;
        push_req   = 1'b0;
`ifdef JOY_EVENT_DEBOUNCE_EN
        pend_d     = pend_q;
`endif

        case (state_q)
            IDLE: begin
                if (vblank_rise) begin
                    for (int p = 0; p < MAX_SCAN_PLAYERS; p++) begin
                        snap_d[p*BITS_PER_PLAYER +: BITS_PER_PLAYER] =
                            joystick[p*PLAYER_WORD_W +: BITS_PER_PLAYER];
                    end
                    four_d   = player_count;
                    frame_d  = frame_q + 8'd1;
                    player_d = '0;
                    bit_d    = '0;
                    state_d  = SCAN;
                    busy_d   = 1'b1;
                end
            end

            SCAN: begin
`ifdef JOY_EVENT_DEBOUNCE_EN
                // First differing scan only arms the pending bit; a second
                // consecutive differing scan commits the event.
                if (cur_bit != prev_bit) begin
                    if (pend_q[scan_idx]) begin
                        push_req         = 1'b1;
                        prev_d[scan_idx] = cur_bit;
                        pend_d[scan_idx] = 1'b0;
                    end else begin
                        pend_d[scan_idx] = 1'b1;
                    end
                end else begin
                    pend_d[scan_idx] = 1'b0;
                end
`else
                if (cur_bit != prev_bit) begin
                    push_req         = 1'b1;
                    // Updated even when the FIFO drops the event.
                    prev_d[scan_idx] = cur_bit;
                end
`endif
                if (bit_q == LAST_BIT) begin
                    bit_d = '0;
                    if (player_q == last_player) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        player_d = player_q + 2'd1;
                    end
                end else begin
                    bit_d = bit_q + BIT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // A drop in the same cycle as a clear keeps overflow set.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_overflow) begin
            overflow_d = 1'b0;
        end else begin
            overflow_d = overflow_q;
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            vblank_q   <= 1'b0;
            frame_q    <= '0;
            snap_q     <= '0;
            prev_q     <= '0;
            four_q     <= 1'b0;
            player_q   <= '0;
            bit_q      <= '0;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
`ifdef JOY_EVENT_DEBOUNCE_EN
            pend_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            vblank_q   <= vblank;
            frame_q    <= frame_d;
            snap_q     <= snap_d;
            prev_q     <= prev_d;
            four_q     <= four_d;
            player_q   <= player_d;
            bit_q      <= bit_d;
            busy_q     <= busy_d;
            overflow_q <= overflow_d;
`ifdef JOY_EVENT_DEBOUNCE_EN
            pend_q     <= pend_d;
`endif
        end
    end

    event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EVT_W)
    ) u_fifo (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .push      (push_req),
        .push_data (push_evt),
        .pop       (rd),
        .head_data (event_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign event_valid = !fifo_empty;
    assign overflow    = overflow_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_joy_event_queue.sv
// ----------------------------------------------------------------------------
// tb_joy_event_queue
// Self-checking bench for joy_event_queue. Directed scenarios use literal
// expected event words; the randomized scenario uses a behavioural model
// (per-bit previous-state array plus an expected-event queue).
// ----------------------------------------------------------------------------
module tb_joy_event_queue;

    localparam int DEPTH = 16;
    localparam int BPP   = 16;

    logic         clk_sys = 1'b0;
    logic         reset;
    logic [191:0] joystick;
    logic         player_count;
    logic         vblank;
    logic         rd;
    logic         clr_overflow;
    logic [15:0]  event_data;
    logic         event_valid;
    logic         overflow;
    logic         busy;

    int vectors     = 0;
    int miscompares = 0;

    // Behavioural model state
    bit          m_prev [4][BPP];
    bit          m_pend [4][BPP];
    int          m_frame;
    logic [15:0] m_q [$];
    bit          m_ovf;
    logic [15:0] m_last;

    always #5 clk_sys = ~clk_sys;

    joy_event_queue #(
        .FIFO_DEPTH      (DEPTH),
        .BITS_PER_PLAYER (BPP)
    ) dut (
        .clk_sys      (clk_sys),
        .reset        (reset),
        .joystick     (joystick),
        .player_count (player_count),
        .vblank       (vblank),
        .rd           (rd),
        .clr_overflow (clr_overflow),
        .event_data   (event_data),
        .event_valid  (event_valid),
        .overflow     (overflow),
        .busy         (busy)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    function automatic void model_reset();
        for (int p = 0; p < 4; p++)
            for (int b = 0; b < BPP; b++) begin
                m_prev[p][b] = 1'b0;
                m_pend[p][b] = 1'b0;
            end
        m_frame = 0;
        m_q.delete();
        m_ovf  = 1'b0;
        m_last = 16'h0000;
    endfunction

    // One scan as the requirements describe it: compare every scanned bit
    // against its stored state and queue a press/release word on change.
    function automatic void model_scan(input logic [191:0] joy, input bit four);
        m_frame = (m_frame + 1) % 256;
        for (int p = 0; p < (four ? 4 : 2); p++) begin
            for (int b = 0; b < BPP; b++) begin
                bit s;
                s = joy[p*32 + b];
                if (s != m_prev[p][b]) begin
`ifdef JOY_EVENT_DEBOUNCE_EN
                    if (!m_pend[p][b]) begin
                        m_pend[p][b] = 1'b1;
                        continue;
                    end
                    m_pend[p][b] = 1'b0;
`endif
                    if (m_q.size() < DEPTH) m_q.push_back({s, 3'(p), 8'(m_frame), 4'(b)});
                    else m_ovf = 1'b1;
                    m_prev[p][b] = s;
                end else begin
                    m_pend[p][b] = 1'b0;
                end
            end
        end
    endfunction

    task automatic do_reset();
        reset = 1'b1; vblank = 1'b0; rd = 1'b0; clr_overflow = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();
        model_reset();
    endtask

    task automatic start_frame(input string name);
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s busy_start: busy=%b required 1", name, busy);
        end
    endtask

    // elapsed = cycles already spent inside the scan since start_frame
    task automatic finish_frame(input string name, input int elapsed, input int len);
        int cnt;
        cnt = 0;
        while (busy === 1'b1 && cnt < 200) begin
            tick();
            cnt++;
        end
        vectors++;
        if (elapsed + cnt != len) begin
            miscompares++;
            $display("FAIL %s scan_len: busy cycles=%0d required %0d", name, elapsed + cnt, len);
        end
        tick();
    endtask

    task automatic drain_check(input string name);
        logic [15:0] exp;
        while (m_q.size() > 0) begin
            exp = m_q.pop_front();
            vectors++;
            if (event_valid !== 1'b1 || event_data !== exp) begin
                miscompares++;
                $display("FAIL %s event: valid=%b data=%h required valid=1 data=%h",
                         name, event_valid, event_data, exp);
            end
            m_last = exp;
            rd = 1'b1; tick(); rd = 1'b0;
        end
        vectors++;
        if (event_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s drained: event_valid=%b required 0", name, event_valid);
        end
    endtask

    task automatic test_reset();
        joystick = '1; player_count = 1'b1;
        reset = 1'b1; vblank = 1'b0; rd = 1'b0; clr_overflow = 1'b0;
        tick();
        vectors++;
        if (event_valid !== 1'b0 || event_data !== 16'h0 || overflow !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_state: valid=%b data=%h ovf=%b busy=%b required 0/0000/0/0",
                     event_valid, event_data, overflow, busy);
        end
        joystick = '0; player_count = 1'b0;
        do_reset();
    endtask

    task automatic test_single_press();
        joystick = '0; player_count = 1'b0;
        do_reset();
        joystick[4] = 1'b1;
        start_frame("single");
        finish_frame("single", 0, 32);
        m_q.push_back(16'h8014);
        drain_check("single");
    endtask

    task automatic test_order();
        joystick = '0; player_count = 1'b1;
        do_reset();
        joystick[96] = 1'b1;
        joystick[41] = 1'b1;
        start_frame("order_press");
        finish_frame("order_press", 0, 64);
        m_q.push_back(16'h9019);
        m_q.push_back(16'hB010);
        drain_check("order_press");
        joystick = '0;
        start_frame("order_release");
        finish_frame("order_release", 0, 64);
        m_q.push_back(16'h1029);
        m_q.push_back(16'h3020);
        drain_check("order_release");
    endtask

    task automatic test_overflow();
        joystick = '0; player_count = 1'b0;
        do_reset();
        joystick[9:0]   = '1;
        joystick[41:32] = '1;
        start_frame("overflow");
        finish_frame("overflow", 0, 32);
        vectors++;
        if (overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL overflow_set: overflow=%b required 1", overflow);
        end
        clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow_clear: overflow=%b required 0", overflow);
        end
        for (int b = 0; b < 10; b++) m_q.push_back(16'h8010 | 16'(b));
        for (int b = 0; b < 6;  b++) m_q.push_back(16'h9010 | 16'(b));
        drain_check("overflow");
    endtask

    task automatic test_full_with_rd();
        joystick = '0; player_count = 1'b0;
        do_reset();
        joystick[15:0] = '1;
        start_frame("full_fill");
        finish_frame("full_fill", 0, 32);
        joystick = '0;
        start_frame("full_rd");
        // Pop every cycle while the 16 release events are pushed into a full FIFO.
        rd = 1'b1;
        for (int b = 0; b < 16; b++) begin
            vectors++;
            if (event_data !== (16'h8010 | 16'(b))) begin
                miscompares++;
                $display("FAIL full_rd head: data=%h required %h", event_data, 16'h8010 | 16'(b));
            end
            tick();
        end
        rd = 1'b0;
        finish_frame("full_rd", 16, 32);
        vectors++;
        if (overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL full_rd overflow: overflow=%b required 0", overflow);
        end
        for (int b = 0; b < 16; b++) m_q.push_back(16'h0020 | 16'(b));
        drain_check("full_rd");
    endtask

    task automatic test_vblank_during_scan();
        joystick = '0; player_count = 1'b0;
        do_reset();
        joystick[3] = 1'b1;
        start_frame("vb_scan");
        for (int i = 0; i < 9; i++) tick();
        vblank = 1'b1; tick(); vblank = 1'b0;
        finish_frame("vb_scan", 10, 32);
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (busy !== 1'b0) begin
                miscompares++;
                $display("FAIL vb_scan no_rescan: busy=%b required 0", busy);
            end
            tick();
        end
        m_q.push_back(16'h8013);
        drain_check("vb_scan_first");
        joystick = '0;
        start_frame("vb_scan_next");
        finish_frame("vb_scan_next", 0, 32);
        m_q.push_back(16'h0023);
        drain_check("vb_scan_next");
    endtask

    task automatic test_reset_mid_scan();
        joystick = '0; player_count = 1'b1;
        do_reset();
        for (int w = 0; w < 6; w++) joystick[w*32 +: 32] = $urandom & $urandom & $urandom;
        joystick[0] = 1'b1;
        start_frame("rst_mid");
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        #1;
        vectors++;
        if (event_valid !== 1'b0 || event_data !== 16'h0 || overflow !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid outputs: valid=%b data=%h ovf=%b busy=%b required 0/0000/0/0",
                     event_valid, event_data, overflow, busy);
        end
        tick();
        reset = 1'b0;
        model_reset();
        tick();
        start_frame("rst_mid_after");
        finish_frame("rst_mid_after", 0, 64);
        model_scan(joystick, 1'b1);
        drain_check("rst_mid_after");
    endtask

    task automatic test_random();
        bit pc;
        int k;
        joystick = '0; player_count = 1'b0;
        do_reset();
        for (int it = 0; it < 12; it++) begin
            for (int w = 0; w < 6; w++)
                joystick[w*32 +: 32] = (it % 4 == 3) ? $urandom : ($urandom & $urandom & $urandom);
            pc = 1'($urandom_range(0, 1));
            player_count = pc;
            start_frame("random");
            k = $urandom_range(1, 20);
            for (int i = 0; i < k; i++) tick();
            player_count = 1'($urandom_range(0, 1));
            finish_frame("random", k, pc ? 64 : 32);
            model_scan(joystick, pc);
            vectors++;
            if (overflow !== m_ovf) begin
                miscompares++;
                $display("FAIL random overflow it=%0d: overflow=%b required %b", it, overflow, m_ovf);
            end
            if (m_ovf) begin
                clr_overflow = 1'b1; tick(); clr_overflow = 1'b0;
                m_ovf = 1'b0;
                vectors++;
                if (overflow !== 1'b0) begin
                    miscompares++;
                    $display("FAIL random overflow_clear it=%0d: overflow=%b required 0", it, overflow);
                end
            end
            drain_check("random");
        end
    endtask

    task automatic test_rd_empty();
        rd = 1'b1; tick(); tick(); rd = 1'b0;
        vectors++;
        if (event_valid !== 1'b0 || event_data !== m_last) begin
            miscompares++;
            $display("FAIL rd_empty: valid=%b data=%h required valid=0 data=%h",
                     event_valid, event_data, m_last);
        end
    endtask

`ifdef JOY_EVENT_DEBOUNCE_EN
    task automatic test_debounce();
        joystick = '0; player_count = 1'b0;
        do_reset();
        joystick[2] = 1'b1;
        start_frame("deb_glitch"); finish_frame("deb_glitch", 0, 32);
        joystick[2] = 1'b0;
        start_frame("deb_glitch2"); finish_frame("deb_glitch2", 0, 32);
        drain_check("deb_glitch");
        joystick[2] = 1'b1;
        start_frame("deb_hold1"); finish_frame("deb_hold1", 0, 32);
        start_frame("deb_hold2"); finish_frame("deb_hold2", 0, 32);
        m_q.push_back(16'h8042);
        drain_check("deb_hold");
    endtask
`endif

    initial begin
        test_reset();
`ifdef JOY_EVENT_DEBOUNCE_EN
        test_debounce();
`else
        test_single_press();
        test_order();
        test_overflow();
        test_full_with_rd();
        test_vblank_during_scan();
`endif
        test_reset_mid_scan();
        test_random();
        test_rd_empty();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/joy_event_queue.md
JOY_EVENT_QUEUE -- requirements
Module: joy_event_queue

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, event FIFO entries (power of two, 4..64).
REQ-002 SHALL have parameter BITS_PER_PLAYER, default 16, joystick bits scanned per player.
REQ-003 SHALL have port clk_sys  input  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port joystick  input  192  six 32-bit player words, player 0 in [31:0].
REQ-006 SHALL have port player_count  input  1  0 = scan players 0-1, 1 = scan players 0-3.
REQ-007 SHALL have port vblank  input  1  video vertical blank, sampling trigger.
REQ-008 SHALL have port rd  input  1  pop head event.
REQ-009 SHALL have port clr_overflow  input  1  clear sticky overflow.
REQ-010 SHALL have port event_data  output  16  head event: [15] pressed, [14:12] player, [11:4] frame[7:0], [3:0] bit index.
REQ-011 SHALL have port event_valid  output  1  FIFO non-empty.
REQ-012 SHALL have port overflow  output  1  sticky: event dropped on full FIFO.
REQ-013 SHALL have port busy  output  1  scan in progress.

Function
REQ-014 Rising edge of vblank SHALL be detected against a registered copy; edge acts one cycle after vblank goes high.
REQ-015 In IDLE, a detected edge SHALL capture joystick bits [BITS_PER_PLAYER-1:0] of players 0-3 into a snapshot, increment the 8-bit frame counter (wraps 255->0), and enter SCAN.
REQ-016 SCAN SHALL visit one (player, bit) per cycle, player-major, bit 0 first; 32 cycles for 2 players, 64 for 4; then return to IDLE; busy high exactly during SCAN.
REQ-017 At each visit where snapshot bit differs from stored previous bit, SHALL push one event (pressed = snapshot bit, frame = counter value of this scan) and update previous bit.
REQ-018 Players 4-5 and joystick bits >= BITS_PER_PLAYER SHALL never be scanned or stored.
REQ-019 vblank edges during SCAN SHALL be ignored: no snapshot, no frame increment.
REQ-020 FIFO SHALL be first-word fall-through: event_data valid whenever event_valid high; rd pops in same cycle.
REQ-021 rd while empty SHALL be ignored; event_data holds last value.
REQ-022 Push while full SHALL drop the event, set overflow, and still update previous bit.
REQ-023 Simultaneous push and rd while full SHALL accept both; no overflow.
REQ-024 clr_overflow SHALL clear overflow next cycle; a drop in that same cycle SHALL win (overflow stays 1).
REQ-025 player_count change mid-SCAN SHALL take effect at the next scan only (latched at snapshot).

Reset
REQ-026 reset SHALL force: state IDLE, FIFO empty, event_valid 0, event_data 0, overflow 0, busy 0, frame counter 0, previous bits all 0, registered vblank 0.
REQ-027 reset asserted mid-SCAN SHALL abort the scan with no partial events retained.
REQ-028 Inputs held at reset release SHALL produce press events on the first scan.

Configuration
REQ-029 Macro JOY_EVENT_DEBOUNCE_EN defined: an event SHALL only be generated when a bit has differed from previous in two consecutive scans with the same value; a single-scan glitch generates nothing.
REQ-030 Macro JOY_EVENT_DEBOUNCE_EN undefined: events SHALL be generated on first differing scan (REQ-017); no pending-bit storage synthesized.

Structure
REQ-031 Package joy_event_pkg SHALL hold EVT_W=16, field offsets of event_data, MAX_SCAN_PLAYERS=4, and the state enum (IDLE, SCAN).
REQ-032 The FIFO SHALL be sub-module event_fifo (synchronous, FWFT, FIFO_DEPTH x EVT_W, full/empty flags).

Verification
REQ-033 Reset, player_count=0, joystick[4]=1 (p0 bit4), one vblank pulse -> after 33 cycles exactly one event 16'h8014 (pressed, p0, frame 1, bit 4).
REQ-034 player_count=1, set p3 bit 0 and p1 bit 9, vblank; then clear both, vblank -> events in order 16'h9019, 16'hB010, 16'h1029, 16'h3020.
REQ-035 Set 20 distinct bits across p0-p1 with FIFO_DEPTH=16, no rd, vblank -> 16 events queued, overflow=1; pulse clr_overflow -> overflow=0; drain 16, event_valid=0.
REQ-036 Second vblank pulse 10 cycles into a scan -> no extra scan, frame field of next scan increments by 1 only.
REQ-037 With JOY_EVENT_DEBOUNCE_EN: p0 bit 2 high for one frame only -> zero events; high for two frames -> one press event tagged with second frame number.
REQ-038 reset asserted mid-SCAN with bits held -> all outputs zero; after release and next vblank, press events re-issued with frame 1.
